hi_lo_control: RTL and testbench
================================

HI_LO_CONTROL -- requirements
Module: hi_lo_control

Interface
- REQ-001 SHALL use reset reset, synchronous, active-high; clock clk.
- REQ-002 clk  input  1  rising-edge clock for the HI and LO registers.
- REQ-003 reset  input  1  synchronous active-high reset.
- REQ-004 opcode  input  6  instruction bits [31:26].
- REQ-005 func_code  input  6  instruction bits [5:0].
- REQ-006 state  input  3  CPU state: 0 IF, 1 ID, 2 EX, 3 MEM, 4 WB.
- REQ-007 regA  input  32  rs operand, the MTHI/MTLO source.
- REQ-008 ALU_MULTorDIV_result  input  64  [63:32] is the HI value and [31:0] is the LO value. MULT gives the product; DIV gives {remainder, quotient}.
- REQ-009 HI  output  32  HI register.
- REQ-010 LO  output  32  LO register.
- REQ-011 HI_LO_ALUOut  output  2  writeback source select: 0 ALUOut, 1 HI, 2 LO.

Function
- REQ-012 SHALL decode only when opcode==6'h00 (SPECIAL). Any other opcode SHALL leave HI/LO unchanged and drive HI_LO_ALUOut=0, whatever func_code is.
- REQ-013 SPECIAL func_code 6'h18 MULT and 6'h19 MULTU SHALL load HI<=result[63:32] and LO<=result[31:0].
- REQ-014 SPECIAL func_code 6'h1A DIV and 6'h1B DIVU SHALL load HI/LO the same way (see REQ-024).
- REQ-015 SPECIAL 6'h11 MTHI SHALL load HI<=regA with LO unchanged. SPECIAL 6'h13 MTLO SHALL load LO<=regA with HI unchanged.
- REQ-016 All HI/LO writes SHALL occur only on a rising clk edge while state==2 (EX). No writes SHALL occur in any other state.
- REQ-017 If EX is held for several cycles (bus stall), the write SHALL repeat each cycle. Inputs are stable during the hold, so the result SHALL be idempotent.
- REQ-018 HI_LO_ALUOut SHALL be combinational and independent of state:
  - 1 for SPECIAL 6'h10 MFHI;
  - 2 for SPECIAL 6'h12 MFLO;
  - 0 for everything else.
  - The value 3 SHALL never be driven.
- REQ-019 Latency: a written value SHALL be visible on HI/LO the cycle after the EX edge. An MFHI/MFLO in the next instruction SHALL read the new value.
- REQ-020 HI and LO SHALL be plain registers with no bypass from inputs to outputs.

Reset
- REQ-021 With reset=1 at a rising edge, HI and LO SHALL become 32'h0.
- REQ-022 Reset SHALL take priority over any simultaneous write, including during EX mid-instruction.
- REQ-023 HI_LO_ALUOut has no state and SHALL follow its inputs during reset.

Configuration
- REQ-024 Macro HI_LO_DIV_EN:
  - When defined, DIV/DIVU SHALL update HI/LO per REQ-014.
  - When undefined, DIV/DIVU SHALL be no-ops for HI/LO. MULT/MULTU/MTHI/MTLO/MFHI/MFLO SHALL be unaffected.

Structure
- REQ-025 A shared package SHALL hold:
  - the opcode and func_code constants (SPECIAL, MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU);
  - the 3-bit state encoding constants (IF/ID/EX/MEM/WB);
  - the 2-bit writeback-select constants (SEL_ALUOUT=0, SEL_HI=1, SEL_LO=2).
- REQ-026 One combinational sub-module hi_lo_decode SHALL map opcode/func_code to the signals we_hi, we_lo, src_is_regA and the select value. The top SHALL hold only the registers.

Verification
- REQ-027 Reset: assert reset, then MTHI with regA=32'hDEAD_BEEF in EX -> HI=0 and LO=0 after the edge, because reset wins.
- REQ-028 MULT: opcode=0, func=18, state=2, result=64'h0000_0001_FFFF_FFFE -> HI=32'h1 and LO=32'hFFFF_FFFE next cycle.
- REQ-029 MTLO gating: func=13, regA=32'h1234_5678, held in state=1 then state=2 -> LO unchanged after the state-1 edge, LO=32'h1234_5678 after the state-2 edge, HI unchanged.
- REQ-030 Select: func=10 -> HI_LO_ALUOut=1; func=12 -> 2; opcode=6'h23 with func=10 -> 0.
- REQ-031 DIV: func=1A, result={32'h3, 32'h7}, state=2 -> HI=3 and LO=7 with HI_LO_DIV_EN defined; HI/LO unchanged without it.
- REQ-032 Stalled EX: MTHI held 3 cycles in state=2 with regA=32'hA5A5_A5A5 -> HI=32'hA5A5_A5A5 throughout and LO untouched.

Source files
------------

// File: rtl/hi_lo_control_pkg.sv
// Shared constants for the HI/LO register block: instruction fields, CPU state
// encoding and writeback-select values.
package hi_lo_control_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  localparam logic [2:0] ST_IF  = 3'd0;
  localparam logic [2:0] ST_ID  = 3'd1;
  localparam logic [2:0] ST_EX  = 3'd2;
  localparam logic [2:0] ST_MEM = 3'd3;
  localparam logic [2:0] ST_WB  = 3'd4;

  localparam logic [1:0] SEL_ALUOUT = 2'd0;
  localparam logic [1:0] SEL_HI     = 2'd1;
  localparam logic [1:0] SEL_LO     = 2'd2;

endpackage

// File: rtl/hi_lo_control_if.sv
// Bundle of the CPU-side signals of the HI/LO block; the slave modport is the
// register block, the master modport is the CPU datapath driving it.
interface hi_lo_control_if;
  import hi_lo_control_pkg::*;

  logic [5:0]  opcode;
  logic [5:0]  func_code;
  logic [2:0]  state;
  logic [31:0] regA;
  logic [63:0] ALU_MULTorDIV_result;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [1:0]  HI_LO_ALUOut;

  modport master (
    output opcode, func_code, state, regA, ALU_MULTorDIV_result,
    input  HI, LO, HI_LO_ALUOut
  );

  modport slave (
    input  opcode, func_code, state, regA, ALU_MULTorDIV_result,
    output HI, LO, HI_LO_ALUOut
  );
endinterface

// File: rtl/hi_lo_decode.sv
// Combinational decode of SPECIAL HI/LO instructions into write enables, source
// select and writeback select. DIV/DIVU write HI/LO only when HI_LO_DIV_EN is defined.
module hi_lo_decode
  import hi_lo_control_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func_code,
  output logic       we_hi,
  output logic       we_lo,
  output logic       src_is_regA,
  output logic [1:0] sel
);

  always_comb begin
    we_hi       = 1'b0;
    we_lo       = 1'b0;
    src_is_regA = 1'b0;
    sel         = SEL_ALUOUT;
    if (opcode == OP_SPECIAL) begin
      case (func_code)
        FN_MULT, FN_MULTU: begin
          we_hi = 1'b1;
          we_lo = 1'b1;
        end
`ifdef HI_LO_DIV_EN
        FN_DIV, FN_DIVU: begin
          we_hi = 1'b1;
          we_lo = 1'b1;
        end
`else
        FN_DIV, FN_DIVU: ;
`endif
        FN_MTHI: begin
          we_hi       = 1'b1;
          src_is_regA = 1'b1;
        end
        FN_MTLO: begin
          we_lo       = 1'b1;
          src_is_regA = 1'b1;
        end
        FN_MFHI: sel = SEL_HI;
        FN_MFLO: sel = SEL_LO;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hi_lo_control.sv
// HI/LO register pair written in the EX state by MULT/DIV/MTHI/MTLO.
// Optional feature: define HI_LO_DIV_EN to let DIV/DIVU update HI/LO.
module hi_lo_control
  import hi_lo_control_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  hi_lo_control_if.slave  bus
);

  logic        we_hi;
  logic        we_lo;
  logic        src_is_regA;
  logic [1:0]  sel;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  hi_lo_decode u_decode (
    .opcode      (bus.opcode),
    .func_code   (bus.func_code),
    .we_hi       (we_hi),
    .we_lo       (we_lo),
    .src_is_regA (src_is_regA),
    .sel         (sel)
  );

  // Writes repeat every cycle while EX is held; stable inputs make this harmless.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= 32'h0;
      lo_q <= 32'h0;
    end else if (bus.state == ST_EX) begin
      if (we_hi) hi_q <= src_is_regA ? bus.regA : bus.ALU_MULTorDIV_result[63:32];
      if (we_lo) lo_q <= src_is_regA ? bus.regA : bus.ALU_MULTorDIV_result[31:0];
    end
  end

  assign bus.HI           = hi_q;
  assign bus.LO           = lo_q;
  assign bus.HI_LO_ALUOut = sel;

endmodule

// File: tb/tb_hi_lo_control.sv
// Self-checking bench for hi_lo_control: directed cases then random instructions
// compared against an instruction-level HI/LO model.
module tb_hi_lo_control;
  logic clk = 1'b0;
  logic reset;
  int   total  = 0;
  int   passed = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  hi_lo_control_if bus ();

  hi_lo_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_sel(input logic [5:0] op, input logic [5:0] fn);
    if (op != 6'h00) return 2'd0;
    if (fn == 6'h10) return 2'd1;
    if (fn == 6'h12) return 2'd2;
    return 2'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, check the select, clock once, check HI/LO.
  task automatic step(input string tag, input logic rst, input logic [5:0] op,
                      input logic [5:0] fn, input logic [2:0] st, input logic [31:0] a,
                      input logic [63:0] res);
    reset                    = rst;
    bus.opcode               = op;
    bus.func_code            = fn;
    bus.state                = st;
    bus.regA                 = a;
    bus.ALU_MULTorDIV_result = res;
    #1;
    check({tag, "_sel"}, {30'd0, bus.HI_LO_ALUOut}, {30'd0, exp_sel(op, fn)});
    if (rst) begin
      m_hi = 32'h0;
      m_lo = 32'h0;
    end else if (st == 3'd2 && op == 6'h00) begin
      if (fn == 6'h18 || fn == 6'h19) begin
        m_hi = res[63:32];
        m_lo = res[31:0];
      end
`ifdef HI_LO_DIV_EN
      if (fn == 6'h1A || fn == 6'h1B) begin
        m_hi = res[63:32];
        m_lo = res[31:0];
      end
`endif
      if (fn == 6'h11) m_hi = a;
      if (fn == 6'h13) m_lo = a;
    end
    @(posedge clk);
    #1;
    check({tag, "_hi"}, bus.HI, m_hi);
    check({tag, "_lo"}, bus.LO, m_lo);
  endtask

  initial begin
    logic [5:0] fns [11];
    logic [5:0] op, fn;
    fns = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h00, 6'h3F};
    m_hi = 32'h0;
    m_lo = 32'h0;

    step("reset_wins", 1'b1, 6'h00, 6'h11, 3'd2, 32'hDEAD_BEEF, 64'h0);
    step("mult", 1'b0, 6'h00, 6'h18, 3'd2, 32'h0, 64'h0000_0001_FFFF_FFFE);
    step("mtlo_id", 1'b0, 6'h00, 6'h13, 3'd1, 32'h1234_5678, 64'h0);
    step("mtlo_ex", 1'b0, 6'h00, 6'h13, 3'd2, 32'h1234_5678, 64'h0);
    step("mfhi", 1'b0, 6'h00, 6'h10, 3'd2, 32'h0, 64'h0);
    step("mflo", 1'b0, 6'h00, 6'h12, 3'd0, 32'h0, 64'h0);
    step("lw_func10", 1'b0, 6'h23, 6'h10, 3'd2, 32'h0, 64'h0);
    step("lw_mult", 1'b0, 6'h23, 6'h18, 3'd2, 32'h0, 64'hFFFF_0000_0000_FFFF);
    step("div", 1'b0, 6'h00, 6'h1A, 3'd2, 32'h0, {32'h3, 32'h7});
    step("divu", 1'b0, 6'h00, 6'h1B, 3'd2, 32'h0, {32'h9, 32'h4});
    for (int i = 0; i < 3; i++) begin
      step("stall_mthi", 1'b0, 6'h00, 6'h11, 3'd2, 32'hA5A5_A5A5, 64'h0);
    end
    step("multu_wb", 1'b0, 6'h00, 6'h19, 3'd4, 32'h0, 64'h1111_2222_3333_4444);
    step("reset_mid", 1'b1, 6'h00, 6'h18, 3'd2, 32'h0, 64'h1111_2222_3333_4444);

    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00;
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 10)];
      step("rand", ($urandom_range(0, 24) == 0), op, fn, 3'($urandom_range(0, 4)),
           $urandom, {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
